// File: rtl/fft_frame_source.sv
// Buffers a free-running real sample stream and frames it into FFT_POINTS-beat Avalon-ST packets.
// Optional macro FFT_FRAME_ERR_EN: flags frames that lost samples via src_error on the EOP beat.
module fft_frame_source #(
    parameter int FFT_POINTS = 1024,
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int INVERSE    = 0
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic                        sample_valid,
    input  logic [SAMPLE_W-1:0]         sample_data,
    output logic                        src_valid,
    input  logic                        src_ready,
    output logic [1:0]                  src_error,
    output logic                        src_startofpacket,
    output logic                        src_endofpacket,
    output logic [32:0]                 src_data,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic [15:0]                 frame_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(FFT_POINTS);
    localparam logic [AW:0]   FULL_LVL = FIFO_DEPTH[AW:0];
    localparam logic [BW-1:0] LAST     = BW'(FFT_POINTS - 1);
    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    IN_PKT   = 1'b1;

    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q, count_d;
    logic                out_valid_q;
    logic [SAMPLE_W-1:0] out_data_q;
    logic [BW-1:0]       beat_idx_q, beat_idx_d;
    logic [0:0]          state_q, state_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic [15:0]         real_w;

    logic full, pop, push, drop, hs, is_sop, is_eop, hs_eop;

    assign full   = (count_q == FULL_LVL);
    // The output register refills whenever it is empty or being drained this cycle.
    assign pop    = (count_q != '0) && (!out_valid_q || src_ready);
    assign push   = sample_valid && (!full || pop);
    assign drop   = sample_valid && full && !pop;
    assign hs     = out_valid_q && src_ready;
    assign is_sop = (beat_idx_q == '0);
    assign is_eop = (beat_idx_q == LAST);
    assign hs_eop = hs && is_eop;

    assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_comb begin
        beat_idx_d    = beat_idx_q;
        state_d       = state_q;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q;
        if (hs)
            beat_idx_d = is_eop ? '0 : beat_idx_q + 1'b1;
        case (state_q)
            IDLE:    if (hs && is_sop) state_d = IN_PKT;
            IN_PKT:  if (hs_eop) begin
                         state_d       = IDLE;
                         frame_count_d = frame_count_q + 16'd1;
                     end
            default: state_d = IDLE;
        endcase
        if (overflow_clr)
            overflow_d = 1'b0;
        else if (drop)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk_clk) begin
        if (push)
            mem_q[wr_ptr_q] <= sample_data;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            beat_idx_q    <= '0;
            state_q       <= IDLE;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mem_q[rd_ptr_q];
            end else if (hs) begin
                out_valid_q <= 1'b0;
            end
            beat_idx_q    <= beat_idx_d;
            state_q       <= state_d;
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef FFT_FRAME_ERR_EN
    logic err_pend_q, err_pend_d;

    // A drop coinciding with the EOP handshake belongs to the following frame.
    assign err_pend_d = hs_eop ? drop : (err_pend_q | drop);

    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            err_pend_q <= 1'b0;
        else
            err_pend_q <= err_pend_d;
    end

    assign src_error = (out_valid_q && is_eop && err_pend_q) ? 2'b01 : 2'b00;
`else
    assign src_error = 2'b00;
`endif

    // Left-justify the sample in the 16-bit real field; imaginary part is zero.
    assign real_w = 16'(out_data_q) << (16 - SAMPLE_W);

    assign src_valid         = out_valid_q;
    assign src_startofpacket = out_valid_q && is_sop;
    assign src_endofpacket   = out_valid_q && is_eop;
    assign src_data          = {(INVERSE != 0), real_w, 16'h0000};
    assign overflow          = overflow_q;
    assign frame_count       = frame_count_q;
    assign fifo_level        = count_q;

endmodule

// File: tb/tb_fft_frame_source.sv
// Scoreboard bench for fft_frame_source with 8-point frames and a 16-entry FIFO.
module tb_fft_frame_source;
    localparam int NPTS  = 8;
    localparam int SW    = 16;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        src_ready = 1'b0;
    logic        overflow_clr = 1'b0;
    logic        src_valid, src_startofpacket, src_endofpacket, overflow;
    logic [1:0]  src_error;
    logic [32:0] src_data;
    logic [15:0] frame_count;
    logic [4:0]  fifo_level;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    int          tb_beat = 0;
    bit          exp_err = 1'b0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    fft_frame_source #(
        .FFT_POINTS(NPTS), .SAMPLE_W(SW), .FIFO_DEPTH(DEPTH), .INVERSE(0)
    ) dut (
        .clk_clk(clk), .reset_reset(rst),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .src_valid(src_valid), .src_ready(src_ready), .src_error(src_error),
        .src_startofpacket(src_startofpacket), .src_endofpacket(src_endofpacket),
        .src_data(src_data), .overflow(overflow), .overflow_clr(overflow_clr),
        .frame_count(frame_count), .fifo_level(fifo_level)
    );

    task automatic check_beat();
        logic [15:0] e;
        logic [1:0]  eerr;
        logic [36:0] act, want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got data=%h, scoreboard empty", src_data);
            return;
        end
        e = exp_q.pop_front();
        eerr = 2'b00;
`ifdef FFT_FRAME_ERR_EN
        if (tb_beat == NPTS - 1 && exp_err) eerr = 2'b01;
`endif
        act  = {src_data, src_startofpacket, src_endofpacket, src_error};
        want = {1'b0, e, 16'h0000, (tb_beat == 0), (tb_beat == NPTS - 1), eerr};
        if (act !== want) begin
            errors++;
            $display("FAIL beat%0d: got {data,sop,eop,err}=%h, required %h", tb_beat, act, want);
        end
        if (tb_beat == NPTS - 1) begin
            tb_beat = 0;
            exp_err = 1'b0;
        end else begin
            tb_beat++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en && src_valid && src_ready) check_beat();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats pending, required 0", exp_q.size());
        end
        tick();
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        tb_beat = 0;
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        logic [59:0] outs;
        rst = 1'b1;
        tick();
        tick();
        outs = {src_valid, src_startofpacket, src_endofpacket, src_error, src_data,
                overflow, frame_count, fifo_level};
        checks++;
        if (outs !== 60'h0) begin
            errors++;
            $display("FAIL reset_during: outputs=%h, required 0", outs);
        end
        rst = 1'b0;
        tick();
        outs = {src_valid, src_startofpacket, src_endofpacket, src_error, src_data,
                overflow, frame_count, fifo_level};
        checks++;
        if (outs !== 60'h0) begin
            errors++;
            $display("FAIL reset_after: outputs=%h, required 0", outs);
        end
    endtask

    task automatic test_two_packets();
        src_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            sample_valid = 1'b1;
            sample_data = 16'(i);
            exp_q.push_back(16'(i));
            tick();
        end
        sample_valid = 1'b0;
        drain(50);
        checks++;
        if (frame_count !== 16'd2) begin
            errors++;
            $display("FAIL two_pkt_count: frame_count=%0d, required 2", frame_count);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL two_pkt_ovf: overflow=%b, required 0", overflow);
        end
    endtask

    task automatic test_latency();
        src_ready = 1'b1;
        sample_valid = 1'b1;
        sample_data = 16'h7FFF;
        exp_q.push_back(16'h7FFF);
        @(negedge clk);
        checks++;
        if (src_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_c0: src_valid=%b, required 0", src_valid);
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (src_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_c1: src_valid=%b, required 0", src_valid);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (src_valid !== 1'b1 || src_data !== 33'h0_7FFF_0000) begin
            errors++;
            $display("FAIL lat_c2: valid=%b data=%h, required 1 and 07fff0000", src_valid, src_data);
        end
        if (src_valid && src_ready) check_beat();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_packet();
        src_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            sample_data = 16'(16'h0100 + i);
            exp_q.push_back(16'(16'h0100 + i));
            tick();
        end
        sample_valid = 1'b0;
        drain(20);
        checks++;
        if (frame_count !== 16'd2) begin
            errors++;
            $display("FAIL midrst_pre_count: frame_count=%0d, required 2", frame_count);
        end
        src_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1;
            sample_data = 16'(16'h0200 + i);
            tick();
        end
        sample_valid = 1'b0;
        tick();
        apply_reset();
        checks++;
        if (src_valid !== 1'b0 || fifo_level !== 5'd0 || frame_count !== 16'd0) begin
            errors++;
            $display("FAIL midrst_flush: valid=%b level=%0d count=%0d, required 0 0 0",
                     src_valid, fifo_level, frame_count);
        end
        tick();
        checks++;
        if (src_valid !== 1'b0 || src_endofpacket !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: valid=%b eop=%b, required 0 0", src_valid, src_endofpacket);
        end
        mon_en = 1'b1;
        src_ready = 1'b1;
        for (int i = 0; i < NPTS; i++) begin
            sample_valid = 1'b1;
            sample_data = 16'(16'h0300 + i);
            exp_q.push_back(16'(16'h0300 + i));
            tick();
        end
        sample_valid = 1'b0;
        drain(30);
        checks++;
        if (frame_count !== 16'd1) begin
            errors++;
            $display("FAIL midrst_count: frame_count=%0d, required 1", frame_count);
        end
    endtask

    task automatic test_backpressure();
        src_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            sample_valid = 1'b1;
            sample_data = 16'(16'h1000 + i);
            if (i <= 17) exp_q.push_back(16'(16'h1000 + i));
            tick();
            if (i == 18) exp_err = 1'b1;
            checks++;
            if (overflow !== (i >= 18)) begin
                errors++;
                $display("FAIL bp_ovf%0d: overflow=%b, required %b", i, overflow, (i >= 18));
            end
            if (i >= 2) begin
                checks++;
                if (src_valid !== 1'b1 || src_data !== {1'b0, 16'h1001, 16'h0000}) begin
                    errors++;
                    $display("FAIL bp_hold%0d: valid=%b data=%h, required 1 010010000", i, src_valid, src_data);
                end
            end
            if (i >= 17) begin
                checks++;
                if (fifo_level !== 5'd16) begin
                    errors++;
                    $display("FAIL bp_level%0d: fifo_level=%0d, required 16", i, fifo_level);
                end
            end
        end
        sample_valid = 1'b0;
        src_ready = 1'b1;
        drain(60);
    endtask

    task automatic test_full_accept();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: overflow=%b, required 0", overflow);
        end
        src_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            sample_valid = 1'b1;
            sample_data = 16'(16'h2000 + i);
            exp_q.push_back(16'(16'h2000 + i));
            tick();
        end
        sample_valid = 1'b0;
        checks++;
        if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill: level=%0d ovf=%b, required 16 0", fifo_level, overflow);
        end
        src_ready = 1'b1;
        sample_valid = 1'b1;
        sample_data = 16'h2100;
        exp_q.push_back(16'h2100);
        tick();
        sample_valid = 1'b0;
        checks++;
        if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_accept: level=%0d ovf=%b, required 16 0", fifo_level, overflow);
        end
        src_ready = 1'b0;
        sample_valid = 1'b1;
        sample_data = 16'h2200;
        overflow_clr = 1'b1;
        tick();
        sample_valid = 1'b0;
        overflow_clr = 1'b0;
        exp_err = 1'b1;
        checks++;
        if (overflow !== 1'b0 || fifo_level !== 5'd16) begin
            errors++;
            $display("FAIL clr_priority: ovf=%b level=%0d, required 0 16", overflow, fifo_level);
        end
        src_ready = 1'b1;
        drain(60);
    endtask

    task automatic test_random();
        int sent = 0;
        int cyc = 0;
        logic [15:0] v;
        apply_reset();
        mon_en = 1'b1;
        while (sent < 1000 && cyc < 20000) begin
            src_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() < 16 && $urandom_range(0, 1) == 1) begin
                v = 16'($urandom);
                sample_valid = 1'b1;
                sample_data = v;
                exp_q.push_back(v);
                sent++;
            end else begin
                sample_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        sample_valid = 1'b0;
        checks++;
        if (sent != 1000) begin
            errors++;
            $display("FAIL rand_budget: sent=%0d, required 1000", sent);
        end
        src_ready = 1'b1;
        drain(100);
        checks++;
        if (frame_count !== 16'd125 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rand_count: frame_count=%0d ovf=%b, required 125 0", frame_count, overflow);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_two_packets();
        test_latency();
        test_reset_mid_packet();
        test_backpressure();
        test_full_accept();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
